// File: rtl/skid_reg_pkg.sv
// Shared types for the backward-path register slice.
package skid_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_st_e;

  localparam int unsigned SKID_ENTRIES = 2;

endpackage

// File: rtl/skid_reg.sv
// Two-entry skid buffer: registered din_ready breaks the combinational ready chain
// while sustaining one transfer per cycle.
module skid_reg
  import skid_reg_pkg::*;
#(
  parameter int unsigned DIN = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           din_valid,
  input  logic [DIN-1:0] din_data,
  output logic           din_ready,
  output logic           dout_valid,
  output logic [DIN-1:0] dout_data,
  input  logic           dout_ready
);

  skid_st_e       r_st;
  skid_st_e       w_st_nxt;
  logic           r_ready;
  logic [DIN-1:0] r_main;
  logic [DIN-1:0] r_skid;

  logic           w_in;
  logic           w_out;
  logic           w_load_main_din;
  logic           w_load_main_skid;
  logic           w_load_skid;

  assign w_in       = din_valid & r_ready;
  assign w_out      = (r_st != EMPTY) & dout_ready;
  assign din_ready  = r_ready;
  assign dout_valid = (r_st != EMPTY);
  assign dout_data  = r_main;

  always_comb begin
    w_st_nxt         = r_st;
    w_load_main_din  = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_st)
      EMPTY: begin
        if (w_in) begin
          w_st_nxt        = BUSY;
          w_load_main_din = 1'b1;
        end
      end
      BUSY: begin
        if (w_in && w_out) begin
          w_load_main_din = 1'b1;
        end else if (w_in) begin
          w_st_nxt    = FULL;
          w_load_skid = 1'b1;
        end else if (w_out) begin
          w_st_nxt = EMPTY;
        end
      end
      FULL: begin
        // din is never sampled here: r_ready was cleared when the skid entry landed
        if (w_out) begin
          w_st_nxt         = BUSY;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_st_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st    <= EMPTY;
      r_ready <= 1'b0;
    end else begin
      r_st    <= w_st_nxt;
      r_ready <= (w_st_nxt != FULL);
    end
  end

  // Data registers carry no reset; dout_data is meaningless while dout_valid is low.
  always_ff @(posedge clk) begin
    if (w_load_main_din) begin
      r_main <= din_data;
    end else if (w_load_main_skid) begin
      r_main <= r_skid;
    end
    if (w_load_skid) begin
      r_skid <= din_data;
    end
  end

endmodule

// File: doc/skid_reg.md
Name: skid_reg

Overview:
- Backward-path register slice for the valid/ready/data handshake; the counterpart of the forward data register.
- `din_ready` is driven directly from a flop, so there is no combinational path from `dout_ready` to `din_ready`.
- Two-entry skid buffer (main register plus skid register) keeps full throughput of one transfer per cycle.
- Inserted between pipeline stages wherever the ready chain limits timing.

Parameters:
- DIN, 16, data width in bits (must be ≥ 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- din_valid  input  1  upstream data valid.
- din_data  input  DIN  upstream data.
- din_ready  output  1  registered ready to upstream.
- dout_valid  output  1  downstream data valid.
- dout_data  output  DIN  downstream data; always the main register.
- dout_ready  input  1  downstream ready.

Behaviour:
- Transfer rules:
  - Upstream transfer occurs when din_valid & din_ready at a rising edge.
  - Downstream transfer occurs when dout_valid & dout_ready at a rising edge.
  - Valid/data from a source stay stable until accepted. The block obeys this on dout and relies on it at din.
- State register st, one of three states:
  - EMPTY: 0 entries.
  - BUSY: main register holds 1 entry.
  - FULL: main and skid registers both hold an entry.
- Outputs:
  - dout_valid = (st != EMPTY).
  - din_ready = ready_q, a flop.
  - ready_q <= (next_st != FULL).
- Reset (async, rst=1):
  - st=EMPTY, ready_q=0, so din_ready=0 and dout_valid=0.
  - Main/skid data registers are not reset; dout_data is don't-care while dout_valid=0.
  - First rising edge after rst deasserts: ready_q becomes 1 and no upstream transfer is possible at that edge. Transfers start from the second edge.
- Transitions (in = upstream transfer, out = downstream transfer):
  - EMPTY & in: main<=din_data, go to BUSY. Latency is 1 cycle from accept to dout_valid.
  - EMPTY & !in: stay EMPTY.
  - BUSY & in & out: main<=din_data, stay BUSY (full-throughput streaming).
  - BUSY & in & !out: skid<=din_data, go to FULL; ready_q<=0.
  - BUSY & !in & out: go to EMPTY.
  - BUSY & !in & !out: hold.
  - FULL & out: main<=skid, go to BUSY; ready_q<=1.
  - FULL & !out: hold; din is ignored because din_ready=0.
- In FULL, din_valid is never sampled. The skid register holds the entry accepted on the edge where ready_q was still 1.
- Ordering is strictly FIFO; at most 2 entries; no entry is dropped or duplicated.
- Throughput is 1 transfer/cycle when dout_ready is held 1.
  - After a stall of N cycles ending in FULL, din_ready recovers 1 cycle after the first downstream transfer.
- Reset mid-operation drops both entries immediately (asynchronously). No pending transfer completes.

Decomposition:
- Shared package skid_reg_pkg holds the state enum type (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) and a helper constant for the entry count.
- Single module; no sub-module is needed. The two data registers and the FSM are small enough to stay inline.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → din_ready=0 and dout_valid=0 immediately. After deassert, din_ready=1 after the first edge, with no accept at that edge.
- Streaming: dout_ready=1 and din_valid=1 with data 0x0001..0x0010 on consecutive cycles → dout_data shows 0x0001..0x0010 one cycle later, one per cycle, din_ready stays 1.
- Skid fill: send 0xA1 then 0xA2 with dout_ready=0 → after 0xA2 is accepted, din_ready=0 and dout_data=0xA1 held. Raise dout_ready → 0xA1 then 0xA2 out on consecutive cycles, and din_ready=1 one cycle after 0xA1 leaves.
- Alternating dout_ready (1,0,1,0…) with continuous din of 0x100+n over 20 items → all 20 out in order, no duplicates, never more than 2 in flight.
- Random din_valid/dout_ready (≥10k cycles, scoreboard) → output sequence equals input sequence. Check that din_ready depends only on prior-cycle state (no same-cycle change when dout_ready toggles).
- Reset while FULL holding 0xB1/0xB2 → both dropped; after recovery, new item 0xC0 appears first on dout.
